zx_kbd_spi_matrix: RTL and testbench

//  Receives ZX key-matrix frames from the USB/PS2/SEGA controller over the KBD_CS/KBD_CLK/KBD_DI SPI link.

---
 rtl/zx_kbd_spi_matrix.sv | 104 ++++++++++
 tb/tb_zx_kbd_spi_matrix.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/zx_kbd_spi_matrix.sv
// zx_kbd_spi_matrix: SPI-fed ZX 8x5 key matrix that supplies KD[4:0] for port #FE reads
//   CLK_14MHZ, CPU_RESET (async, active-low)
//   KBD_CS, KBD_CLK, KBD_DI : SPI link from the keyboard controller (asynchronous pads)
//   A_HI : CPU A[15:8]; a zero bit selects that matrix row
//   KD : active-low column data, rows selected by A_HI ANDed together
//   FRAME_OK / FRAME_ERR : one-cycle commit / discard pulses
//   LINK_UP : a valid frame arrived inside the watchdog window
module zx_kbd_spi_matrix #(
  parameter int FRAME_BITS  = 40,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 21
) (
  input  logic       CLK_14MHZ,
  input  logic       CPU_RESET,
  input  logic       KBD_CS,
  input  logic       KBD_CLK,
  input  logic       KBD_DI,
  input  logic [7:0] A_HI,
  output logic [4:0] KD,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic       LINK_UP
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVF = CW'(FRAME_BITS + 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, di_sync;
  logic cs_s, clk_s, di_s, cs_s_d, clk_s_d;
  logic cs_fall, cs_rise, clk_rise, shift_en, commit, discard, wd_hit;
  logic [FRAME_BITS-1:0] sr, matrix;
  logic [CW-1:0] cnt;
  logic [TIMEOUT_W-1:0] wd;
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign di_s = di_sync[SYNC_STAGES-1];
  assign cs_fall = ~cs_s & cs_s_d;
  assign cs_rise = cs_s & ~cs_s_d;
  assign clk_rise = clk_s & ~clk_s_d;
  // cs_rise implies cs_s=1, so a bit clocked together with deselect is dropped here
  assign shift_en = (state == SHIFT) & clk_rise & ~cs_s;
  assign commit = (state == SHIFT) & cs_rise & (cnt == CNT_FULL);
  assign discard = (state == SHIFT) & cs_rise & (cnt != CNT_FULL);
  // fires only on the step into all-ones, so the matrix is blanked once
  assign wd_hit = (wd == WD_LAST);
  // CS syncs reset high so coming out of reset never looks like a frame start
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) begin
      cs_sync <= '1;
      clk_sync <= '0;
      di_sync <= '0;
      cs_s_d <= 1'b1;
      clk_s_d <= 1'b0;
    end else begin
      cs_sync <= SYNC_STAGES'({cs_sync, KBD_CS});
      clk_sync <= SYNC_STAGES'({clk_sync, KBD_CLK});
      di_sync <= SYNC_STAGES'({di_sync, KBD_DI});
      cs_s_d <= cs_s;
      clk_s_d <= clk_s;
    end
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && cs_fall) state_nx = SHIFT;
    if (state == SHIFT && cs_rise) state_nx = IDLE;
  end
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) begin
      sr <= '0;
      cnt <= '0;
      matrix <= '1;
      wd <= '0;
      FRAME_OK <= 1'b0;
      FRAME_ERR <= 1'b0;
      LINK_UP <= 1'b0;
    end else begin
      FRAME_OK <= commit;
      FRAME_ERR <= discard;
      if (state == IDLE && cs_fall) cnt <= '0;
      else if (shift_en) begin
        sr <= {sr[FRAME_BITS-2:0], di_s};
        cnt <= (cnt == CNT_OVF) ? cnt : cnt + 1'b1;
      end
      if (commit) begin
        matrix <= sr;
        wd <= '0;
        LINK_UP <= 1'b1;
      end else begin
        wd <= (&wd) ? wd : wd + 1'b1;
        if (wd_hit) begin
          matrix <= '1;
          LINK_UP <= 1'b0;
        end
      end
    end
  always_comb begin
    KD = '1;
    for (int r = 0; r < 8; r++) KD = KD & (A_HI[r] ? 5'b11111 : matrix[5*r +: 5]);
  end
endmodule

// File: tb/tb_zx_kbd_spi_matrix.sv
// tb_zx_kbd_spi_matrix: table, corner-sequence and random checks of the SPI key matrix
module tb_zx_kbd_spi_matrix;
  localparam int TW = 12;
  localparam int H = 3;
  localparam int WD_CYC = (1 << TW) - 1;
  logic clk = 0, rst_n = 0, cs = 1, sclk = 0, di = 0;
  logic [7:0] a = 8'hFF;
  logic [4:0] kd;
  logic ok, err, link;
  int ok_cnt = 0, err_cnt = 0, checks = 0, passed = 0;
  zx_kbd_spi_matrix #(.FRAME_BITS(40), .SYNC_STAGES(2), .TIMEOUT_W(TW)) dut (
    .CLK_14MHZ(clk), .CPU_RESET(rst_n), .KBD_CS(cs), .KBD_CLK(sclk), .KBD_DI(di),
    .A_HI(a), .KD(kd), .FRAME_OK(ok), .FRAME_ERR(err), .LINK_UP(link)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ok) ok_cnt++;
    if (err) err_cnt++;
  end
  typedef struct {
    logic [47:0] v;
    int n;
    logic [7:0] a;
    logic [4:0] kd;
    int dok;
    int derr;
    logic link;
  } vec_t;
  vec_t tbl[9];
  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [47:0] v, input int n, input bit tail_clk);
    cs = 0;
    cyc(H);
    for (int i = n - 1; i >= 0; i--) begin
      di = v[i];
      cyc(H);
      sclk = 1;
      cyc(H);
      sclk = 0;
    end
    cyc(H);
    if (tail_clk) sclk = 1;
    cs = 1;
    cyc(8);
    sclk = 0;
    cyc(4);
  endtask
  function automatic logic [4:0] kd_ref(input logic [39:0] m, input logic [7:0] av);
    kd_ref = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!av[r] && !m[5*r+c]) kd_ref[c] = 1'b0;
  endfunction
  task automatic rd(input string nm, input logic [7:0] av, input logic [4:0] exp);
    a = av;
    #2;
    check(nm, 48'(kd), 48'(exp));
  endtask
  initial begin
    logic [39:0] mdl;
    logic [63:0] rnd;
    logic [47:0] v;
    int ok0, err0, n;
    bit prev_err;
    tbl[0] = '{48'h00FF_FFFF_FFFE, 40, 8'hFE, 5'b11110, 1, 0, 1'b1};
    tbl[1] = '{48'h0, 0, 8'hFD, 5'b11111, 0, 0, 1'b1};
    tbl[2] = '{48'h007F_FFFF_FFBF, 40, 8'h7D, 5'b01101, 1, 0, 1'b1};
    tbl[3] = '{48'h0, 0, 8'hFE, 5'b11111, 0, 0, 1'b1};
    tbl[4] = '{48'h0, 0, 8'h7F, 5'b01111, 0, 0, 1'b1};
    tbl[5] = '{48'h0, 39, 8'h7D, 5'b01101, 0, 1, 1'b1};
    tbl[6] = '{48'h0, 41, 8'h7D, 5'b01101, 0, 1, 1'b1};
    tbl[7] = '{48'h0, 0, 8'h00, 5'b01101, 0, 0, 1'b1};
    tbl[8] = '{48'h0, 0, 8'hFF, 5'b11111, 0, 0, 1'b1};
    cyc(3);
    rst_n = 1;
    cyc(4);
    rd("reset_kd", 8'hFE, 5'b11111);
    rd("reset_kd_all", 8'h00, 5'b11111);
    check("reset_link", 48'(link), 48'(0));
    check("reset_pulses", 48'(ok_cnt + err_cnt), 48'(0));
    for (int i = 0; i < 9; i++) begin
      ok0 = ok_cnt;
      err0 = err_cnt;
      if (tbl[i].n > 0) send(tbl[i].v, tbl[i].n, 1'b0);
      rd($sformatf("tbl%0d_kd", i), tbl[i].a, tbl[i].kd);
      check($sformatf("tbl%0d_ok", i), 48'(ok_cnt - ok0), 48'(tbl[i].dok));
      check($sformatf("tbl%0d_err", i), 48'(err_cnt - err0), 48'(tbl[i].derr));
      check($sformatf("tbl%0d_link", i), 48'(link), 48'(tbl[i].link));
    end
    // clocks while deselected are ignored; a clock edge together with deselect is dropped
    for (int i = 0; i < 3; i++) begin
      sclk = 1;
      cyc(H);
      sclk = 0;
      cyc(H);
    end
    mdl = 40'hFF_FFFD_FFFF;
    ok0 = ok_cnt;
    err0 = err_cnt;
    send({8'h0, mdl}, 40, 1'b1);
    check("tail_ok", 48'(ok_cnt - ok0), 48'(1));
    check("tail_err", 48'(err_cnt - err0), 48'(0));
    rd("tail_kd_row3", 8'hF7, kd_ref(mdl, 8'hF7));
    rd("tail_kd_row0", 8'hFE, kd_ref(mdl, 8'hFE));
    // watchdog: commit was about 11 cycles before send returned
    cyc(WD_CYC - 40);
    check("wd_before_link", 48'(link), 48'(1));
    rd("wd_before_kd", 8'hF7, kd_ref(mdl, 8'hF7));
    cyc(60);
    check("wd_after_link", 48'(link), 48'(0));
    rd("wd_after_kd", 8'hF7, 5'b11111);
    rd("wd_after_kd_all", 8'h00, 5'b11111);
    mdl = 40'h7F_FFFF_FFFE;
    send({8'h0, mdl}, 40, 1'b0);
    check("wd_relink", 48'(link), 48'(1));
    rd("wd_relink_kd", 8'h7E, kd_ref(mdl, 8'h7E));
    // reset in the middle of a frame
    cs = 0;
    cyc(H);
    for (int i = 0; i < 20; i++) begin
      di = i[0];
      cyc(H);
      sclk = 1;
      cyc(H);
      sclk = 0;
    end
    rst_n = 0;
    cs = 1;
    cyc(3);
    rd("midrst_kd", 8'h00, 5'b11111);
    check("midrst_link", 48'(link), 48'(0));
    ok0 = ok_cnt;
    err0 = err_cnt;
    rst_n = 1;
    cyc(4);
    mdl = 40'hAB_CDEF_1234;
    send({8'h0, mdl}, 40, 1'b0);
    check("midrst_ok", 48'(ok_cnt - ok0), 48'(1));
    check("midrst_err", 48'(err_cnt - err0), 48'(0));
    check("midrst_link_up", 48'(link), 48'(1));
    for (int r = 0; r < 8; r++) rd($sformatf("midrst_row%0d", r), ~(8'(1) << r), mdl[5*r +: 5]);
    // random frames; never more than one bad frame in a row, so the watchdog stays quiet
    prev_err = 0;
    for (int i = 0; i < 30; i++) begin
      n = prev_err ? 40 : int'($urandom_range(41, 39));
      rnd = {$urandom(), $urandom()};
      v = rnd[47:0];
      ok0 = ok_cnt;
      err0 = err_cnt;
      send(v, n, 1'b0);
      if (n == 40) mdl = v[39:0];
      prev_err = (n != 40);
      check($sformatf("rnd%0d_ok", i), 48'(ok_cnt - ok0), 48'(n == 40));
      check($sformatf("rnd%0d_err", i), 48'(err_cnt - err0), 48'(n != 40));
      check($sformatf("rnd%0d_link", i), 48'(link), 48'(1));
      for (int k = 0; k < 3; k++) begin
        logic [7:0] av;
        av = 8'($urandom);
        rd($sformatf("rnd%0d_kd%0d", i, k), av, kd_ref(mdl, av));
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
